exp_align_pipe: RTL and testbench
=================================

Name: exp_align_pipe

Overview:
Parametrised, pipelined exponent-difference and alignment-control unit for the FPU adder datapath. Accepts two biased exponents per transaction over a valid/ready handshake. Produces the following, two cycles later:
- the absolute exponent difference;
- the sign of the difference;
- a zero flag;
- the larger effective exponent;
- a saturated mantissa-alignment shift amount.

It supports configurable exponent width, a subnormal mode and a sideband tag, and sits between operand unpack and the mantissa alignment shifter.

Parameters:
EXP_W, 8, exponent field width in bits (≥2).
MAN_W, 23, mantissa fraction width; sets the default shift saturation.
SHIFT_MAX, MAN_W+3, saturation value for out_shamt (fraction + hidden/guard/round/sticky span).
DENORM_EN, 1, 1: a zero exponent is treated as effective exponent 1 (subnormal); 0: exponents are used raw.
TAG_W, 4, width of the sideband tag carried alongside each transaction.
(localparam SH_W = $clog2(SHIFT_MAX+1))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept input this cycle
in_ex  in  EXP_W  biased exponent of operand X
in_ey  in  EXP_W  biased exponent of operand Y
in_tag  in  TAG_W  sideband tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_d  out  EXP_W  |Ex_eff − Ey_eff|
out_sgn  out  1  1 when Ey_eff > Ex_eff (Y is larger, operands to be swapped)
out_zero  out  1  1 when out_d == 0
out_emax  out  EXP_W  max(Ex_eff, Ey_eff)
out_shamt  out  SH_W  min(out_d, SHIFT_MAX)
out_tag  out  TAG_W  tag of this result

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Effective exponent:
  - DENORM_EN=1: e_eff = (e==0) ? 1 : e.
  - DENORM_EN=0: e_eff = e.
- Stage 1 (S1), registered on acceptance:
  - diff = {1'b0,Ex_eff} − {1'b0,Ey_eff}, EXP_W+1 bits; borrow bit = sgn.
  - Also registers Ex_eff, Ey_eff and tag.
- Stage 2 (S2), registered:
  - d = sgn ? −diff[EXP_W-1:0] : diff[EXP_W-1:0], always in range 0..2^EXP_W−1.
  - zero = (d==0).
  - emax = sgn ? Ey_eff : Ex_eff.
  - shamt = (d > SHIFT_MAX) ? SHIFT_MAX : d.
  - Tag is forwarded.
- All outputs come directly from S2 registers; no combinational path from in_* data to out_*.
- Handshake:
  - s2_ready = !s2_valid | out_ready.
  - s1_ready = !s1_valid | s2_ready.
  - in_ready = s1_ready.
  - Transfer occurs when valid & ready are both high on a rising edge.
  - A stage register loads only when its ready is high. It loads new data if the upstream is valid; otherwise it clears its valid bit.
- Latency and throughput:
  - 2 cycles from input acceptance to out_valid when unstalled.
  - Throughput of 1 transaction per cycle.
  - At most 2 transactions in flight.
- Stalls:
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - With both stages full, in_ready=0.
  - Data is never dropped or duplicated; order is preserved.
- Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
- in_* contents are ignored when in_valid=0. Data-path registers may update only on load; valid bits are authoritative.
- Reset (with rst high at a clock edge, including mid-operation with either stage full):
  - s1_valid = s2_valid = 0, so out_valid=0.
  - out_d, out_sgn, out_zero, out_emax, out_shamt and out_tag are all 0.
  - in_ready reads 1 from the first cycle after reset.
  - In-flight transactions are discarded.
- Equal exponents give d=0, sgn=0, zero=1, emax=Ex_eff.
- Boundary exponents: 0 and 2^EXP_W−1 (Inf/NaN exponent) are processed arithmetically, with no special-casing; special values are handled downstream.

Test Plan:
(EXP_W=8, MAN_W=23, SHIFT_MAX=26, DENORM_EN=1 unless stated.)
- Ex=130, Ey=127, tag=5, out_ready=1 → exactly 2 cycles later: out_d=3, sgn=0, zero=0, emax=130, shamt=3, tag=5.
- Ex=10, Ey=200 → d=190, sgn=1, zero=0, emax=200, shamt=26 (saturated).
- Subnormal mode:
  - Ex=0, Ey=1 → d=0, zero=1, sgn=0, emax=1.
  - Ex=0, Ey=5 → d=4, sgn=1.
  - Same Ex=0, Ey=5 with DENORM_EN=0 → d=5, emax=5.
- Ex=Ey=255 → d=0, zero=1, sgn=0, emax=255, shamt=0.
- Backpressure: 6 back-to-back inputs (tags 0..5) with out_ready low for 4 cycles after the first output.
  - Outputs hold stable while stalled.
  - in_ready drops once both stages are full.
  - All 6 results emerge in tag order with correct values; no loss or duplicates.
- Reset mid-stream: rst=1 for one cycle with both stages valid → next cycle out_valid=0, all out_* = 0, in_ready=1; a subsequent input yields a correct result 2 cycles after acceptance.

Source files
------------

// File: rtl/exp_align_pipe.sv
// Two-stage exponent-difference / alignment-control pipeline for the FPU adder.
// S1 registers the effective exponents and their signed difference; S2 registers magnitude, sign, max and shift.
module exp_align_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int SHIFT_MAX = MAN_W + 3,
    parameter int DENORM_EN = 1,
    parameter int TAG_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [EXP_W-1:0]                  in_ex,
    input  logic [EXP_W-1:0]                  in_ey,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_W-1:0]                  out_d,
    output logic                              out_sgn,
    output logic                              out_zero,
    output logic [EXP_W-1:0]                  out_emax,
    output logic [$clog2(SHIFT_MAX+1)-1:0]    out_shamt,
    output logic [TAG_W-1:0]                  out_tag
);

    localparam int SH_W = $clog2(SHIFT_MAX + 1);

    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        if (DENORM_EN != 0 && e == '0) return EXP_W'(1);
        return e;
    endfunction

    function automatic logic [EXP_W-1:0] abs_diff(input logic signed [EXP_W:0] diff);
        logic [EXP_W-1:0] lo;
        lo = diff[EXP_W-1:0];
        return diff[EXP_W] ? -lo : lo;
    endfunction

    function automatic logic [SH_W-1:0] sat_shamt(input logic [EXP_W-1:0] d);
        if (32'(d) > 32'(SHIFT_MAX)) return SH_W'(SHIFT_MAX);
        return SH_W'(d);
    endfunction

    logic                    rdy_p1, rdy_p2;
    logic [EXP_W-1:0]        ex_eff_p0, ey_eff_p0;
    logic signed [EXP_W:0]   diff_p0;

    logic                    vld_p1;
    logic signed [EXP_W:0]   diff_p1;
    logic [EXP_W-1:0]        ex_p1, ey_p1;
    logic [TAG_W-1:0]        tag_p1;
    logic [EXP_W-1:0]        d_p1;
    logic                    sgn_p1;

    logic                    vld_p2;
    logic [EXP_W-1:0]        d_p2, emax_p2;
    logic                    sgn_p2, zero_p2;
    logic [SH_W-1:0]         shamt_p2;
    logic [TAG_W-1:0]        tag_p2;

    assign rdy_p2   = !vld_p2 || out_ready;
    assign rdy_p1   = !vld_p1 || rdy_p2;
    assign in_ready = rdy_p1;

    // Stage 0 -> 1: effective exponents and (EXP_W+1)-bit signed difference
    assign ex_eff_p0 = eff_exp(in_ex);
    assign ey_eff_p0 = eff_exp(in_ey);
    assign diff_p0   = $signed({1'b0, ex_eff_p0}) - $signed({1'b0, ey_eff_p0});

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            diff_p1 <= '0;
            ex_p1   <= '0;
            ey_p1   <= '0;
            tag_p1  <= '0;
        end else if (rdy_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                diff_p1 <= diff_p0;
                ex_p1   <= ex_eff_p0;
                ey_p1   <= ey_eff_p0;
                tag_p1  <= in_tag;
            end
        end
    end

    // Stage 1 -> 2: magnitude, sign, larger exponent and saturated shift
    assign sgn_p1 = diff_p1[EXP_W];
    assign d_p1   = abs_diff(diff_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            d_p2     <= '0;
            sgn_p2   <= 1'b0;
            zero_p2  <= 1'b0;
            emax_p2  <= '0;
            shamt_p2 <= '0;
            tag_p2   <= '0;
        end else if (rdy_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                d_p2     <= d_p1;
                sgn_p2   <= sgn_p1;
                zero_p2  <= (d_p1 == '0);
                emax_p2  <= sgn_p1 ? ey_p1 : ex_p1;
                shamt_p2 <= sat_shamt(d_p1);
                tag_p2   <= tag_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_d     = d_p2;
    assign out_sgn   = sgn_p2;
    assign out_zero  = zero_p2;
    assign out_emax  = emax_p2;
    assign out_shamt = shamt_p2;
    assign out_tag   = tag_p2;

endmodule

// File: tb/tb_exp_align_pipe.sv
// Scoreboard bench for exp_align_pipe: a subnormal-mode instance and a raw-exponent instance share stimulus.
// Expected results are computed on acceptance and compared as each result leaves the pipeline.
module tb_exp_align_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       sgn;
        logic       zero;
        logic [7:0] emax;
        logic [4:0] shamt;
        logic [3:0] tag;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_ex = '0, in_ey = '0;
    logic [3:0] in_tag = '0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_sgn, out_zero;
    logic [7:0] out_d, out_emax;
    logic [4:0] out_shamt;
    logic [3:0] out_tag;

    logic       in_ready_r, out_valid_r, out_sgn_r, out_zero_r;
    logic [7:0] out_d_r, out_emax_r;
    logic [4:0] out_shamt_r;
    logic [3:0] out_tag_r;

    int   n_cmp = 0;
    int   n_fail = 0;
    res_t q_den[$];
    res_t q_raw[$];

    always #5 clk = ~clk;

    exp_align_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ex(in_ex), .in_ey(in_ey), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_sgn(out_sgn),
        .out_zero(out_zero), .out_emax(out_emax), .out_shamt(out_shamt), .out_tag(out_tag)
    );

    exp_align_pipe #(.DENORM_EN(0)) u_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_ex(in_ex), .in_ey(in_ey), .in_tag(in_tag),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_d(out_d_r), .out_sgn(out_sgn_r),
        .out_zero(out_zero_r), .out_emax(out_emax_r), .out_shamt(out_shamt_r), .out_tag(out_tag_r)
    );

    function automatic res_t model(input logic [7:0] ex, input logic [7:0] ey,
                                   input logic [3:0] tag, input bit den);
        int   xe, ye, d;
        res_t r;
        xe = (den && ex == 8'd0) ? 1 : int'(ex);
        ye = (den && ey == 8'd0) ? 1 : int'(ey);
        r.sgn   = (ye > xe);
        d       = r.sgn ? ye - xe : xe - ye;
        r.d     = 8'(d);
        r.zero  = (d == 0);
        r.emax  = 8'(r.sgn ? ye : xe);
        r.shamt = 5'(d > 26 ? 26 : d);
        r.tag   = tag;
        return r;
    endfunction

    // Scoreboard: pop/compare on output transfer, push model result on input acceptance.
    always @(negedge clk) begin
        res_t act, exp_r;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                act = {out_d, out_sgn, out_zero, out_emax, out_shamt, out_tag};
                if (q_den.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_den_extra got tag=%0d want no output", out_tag);
                end else begin
                    exp_r = q_den.pop_front();
                    if (act !== exp_r) begin
                        n_fail++;
                        $display("FAIL sb_den got d=%0d sgn=%0b zero=%0b emax=%0d shamt=%0d tag=%0d want d=%0d sgn=%0b zero=%0b emax=%0d shamt=%0d tag=%0d",
                                 act.d, act.sgn, act.zero, act.emax, act.shamt, act.tag,
                                 exp_r.d, exp_r.sgn, exp_r.zero, exp_r.emax, exp_r.shamt, exp_r.tag);
                    end
                end
            end
            if (out_valid_r && out_ready) begin
                n_cmp++;
                act = {out_d_r, out_sgn_r, out_zero_r, out_emax_r, out_shamt_r, out_tag_r};
                if (q_raw.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_raw_extra got tag=%0d want no output", out_tag_r);
                end else begin
                    exp_r = q_raw.pop_front();
                    if (act !== exp_r) begin
                        n_fail++;
                        $display("FAIL sb_raw got d=%0d sgn=%0b zero=%0b emax=%0d shamt=%0d tag=%0d want d=%0d sgn=%0b zero=%0b emax=%0d shamt=%0d tag=%0d",
                                 act.d, act.sgn, act.zero, act.emax, act.shamt, act.tag,
                                 exp_r.d, exp_r.sgn, exp_r.zero, exp_r.emax, exp_r.shamt, exp_r.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q_den.push_back(model(in_ex, in_ey, in_tag, 1'b1));
                q_raw.push_back(model(in_ex, in_ey, in_tag, 1'b0));
            end
        end
    end

    task automatic send(input logic [7:0] ex, input logic [7:0] ey, input logic [3:0] tag);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_ex    = ex;
        in_ey    = ey;
        in_tag   = tag;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout tag=%0d got in_ready=0 want 1", tag);
        end
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 40 && (q_den.size() != 0 || q_raw.size() != 0); i++) @(negedge clk);
        n_cmp++;
        if (q_den.size() != 0 || q_raw.size() != 0) begin
            n_fail++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", q_den.size(), q_raw.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_after_reset(input string name);
        n_cmp++;
        if ({out_valid, out_valid_r} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_valid got %b%b want 00", name, out_valid, out_valid_r);
        end
        n_cmp++;
        if ({out_d, out_sgn, out_zero, out_emax, out_shamt, out_tag} !== 27'd0) begin
            n_fail++;
            $display("FAIL %s_data got d=%0d sgn=%0b zero=%0b emax=%0d shamt=%0d tag=%0d want all 0",
                     name, out_d, out_sgn, out_zero, out_emax, out_shamt, out_tag);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready got %b want 1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset("reset");
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(8'd130, 8'd127, 4'd5);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_d !== 8'd3 || out_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL latency_2 got valid=%b d=%0d tag=%0d want valid=1 d=3 tag=5",
                     out_valid, out_d, out_tag);
        end
        wait_drain();
    endtask

    task automatic test_values();
        out_ready = 1'b1;
        send(8'd10,  8'd200, 4'd1);
        send(8'd0,   8'd1,   4'd2);
        send(8'd0,   8'd5,   4'd3);
        send(8'd255, 8'd255, 4'd4);
        send(8'd255, 8'd0,   4'd6);
        send(8'd0,   8'd0,   4'd7);
        send(8'd40,  8'd14,  4'd8);
        send(8'd40,  8'd13,  4'd9);
        send(8'd1,   8'd0,   4'd10);
        for (int i = 0; i < 6; i++)
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(11 + i));
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit   saw_block;
        res_t snap, cur;
        bit   got_first;
        saw_block = 1'b0;
        got_first = 1'b0;
        out_ready = 1'b1;
        fork
            begin
                for (int t = 0; t < 6; t++) send(8'(20 + 7 * t), 8'(60 - 9 * t), 4'(t));
            end
            begin
                for (int i = 0; i < 30 && !got_first; i++) begin
                    @(negedge clk);
                    got_first = out_valid;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    cur = {out_d, out_sgn, out_zero, out_emax, out_shamt, out_tag};
                    if (in_ready === 1'b0) saw_block = 1'b1;
                    if (i == 0) snap = cur;
                    else begin
                        n_cmp++;
                        if (cur !== snap || out_valid !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stall_hold cycle=%0d got tag=%0d d=%0d valid=%b want tag=%0d d=%0d valid=1",
                                     i, cur.tag, cur.d, out_valid, snap.tag, snap.d);
                        end
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n_cmp++;
        if (!got_first || !saw_block) begin
            n_fail++;
            $display("FAIL stall_in_ready got first=%b blocked=%b want 1 1", got_first, saw_block);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'd50, 8'd52, 4'd12);
        send(8'd90, 8'd33, 4'd13);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_before_reset got valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_den.delete();
        q_raw.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle_after_reset("reset_mid");
        @(posedge clk);
        #1;
        send(8'd100, 8'd90, 4'd9);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_d !== 8'd10 || out_emax !== 8'd100 || out_tag !== 4'd9) begin
            n_fail++;
            $display("FAIL post_reset got valid=%b d=%0d emax=%0d tag=%0d want 1 10 100 9",
                     out_valid, out_d, out_emax, out_tag);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
